bus_master_port: RTL and testbench

Master-side endpoint of the system bus: the initiator that drives an arbiter's mN_request/mN_slave_sel and consumes its grant. Accepts one parallel read/write command from local logic, requests the bus, and shifts address and write data out bit-serially once granted. For reads it collects serial read data from the selected slave, then pulses trans_done so the arbiter releases the bus. One instance per master (m1, m2).

---
 rtl/bus_pkg.sv | 28 ++
 rtl/bus_master_port_if.sv | 42 ++++
 rtl/bus_shift_unit.sv | 59 +++++
 rtl/bus_master_port.sv | 270 +++++++++++++++++++++++++++
 tb/tb_bus_master_port.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: master FSM state encoding, slave ids and bus mode
// values used by the master port, the arbiter and the slave ports.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_ADDR  = 3'd2,
    ST_WDATA = 3'd3,
    ST_RWAIT = 3'd4,
    ST_RDATA = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  localparam logic [1:0] SLAVE0 = 2'b00;
  localparam logic [1:0] SLAVE1 = 2'b01;
  localparam logic [1:0] SLAVE2 = 2'b10;
  localparam logic [1:0] SLAVE3 = 2'b11;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Larger of two elaboration-time integers, used to size the shared shifter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_master_port_if.sv
// Local command/response handshake plus the serial bus and arbiter signals
// of one bus master. The master modport is the port logic; the slave modport
// is whatever sits on the other side (local logic, arbiter, slave model).
interface bus_master_port_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [1:0]        cmd_slave;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              request;
  logic [1:0]        slave_sel;
  logic              grant;
  logic              trans_done;
  logic              bus_out;
  logic              bus_out_valid;
  logic              bus_mode;
  logic              bus_in;
  logic              bus_in_valid;

  modport master (
    input  cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata,
    input  grant, bus_in, bus_in_valid,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output request, slave_sel, trans_done, bus_out, bus_out_valid, bus_mode
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata,
    output grant, bus_in, bus_in_valid,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  request, slave_sel, trans_done, bus_out, bus_out_valid, bus_mode
  );

endinterface

// File: rtl/bus_shift_unit.sv
// Shared PISO/SIPO shifter. Shifts right: bit 0 leaves first on the serial
// output, new serial bits enter at the top, so after PW shifts the collected
// word sits in the top PW bits. The bit counter restarts on load or clear.
// Next-state values are exported so the owner can register its outputs.
module bus_shift_unit #(
  parameter int W     = 12,
  parameter int PW    = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             ser_in,
  input  logic [CNT_W-1:0] len,
  output logic             ser_next,
  output logic [PW-1:0]    par_next,
  output logic             at_last
);

  logic [W-1:0]     sreg_r;
  logic [W-1:0]     sreg_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;

  // Next shift register and counter contents; load has priority over shift.
  always_comb begin
    sreg_next_s = sreg_r;
    cnt_next_s  = cnt_r;
    if (load) begin
      sreg_next_s = load_data;
      cnt_next_s  = {CNT_W{1'b0}};
    end else if (shift_en) begin
      sreg_next_s = {ser_in, sreg_r[W-1:1]};
      cnt_next_s  = clear ? {CNT_W{1'b0}} : (cnt_r + {{(CNT_W-1){1'b0}}, 1'b1});
    end else if (clear) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r;
    end
    ser_next = sreg_next_s[0];
    par_next = sreg_next_s[W-1 -: PW];
    at_last  = (cnt_r == (len - {{(CNT_W-1){1'b0}}, 1'b1}));
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_r <= {W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
    end else begin
      sreg_r <= sreg_next_s;
      cnt_r  <= cnt_next_s;
    end
  end

endmodule

// File: rtl/bus_master_port.sv
// Master-side bus endpoint: accepts one local read/write command, requests
// the bus, serialises address (and write data) once granted, collects serial
// read data, then pulses trans_done/rsp_valid. All outputs are registered
// from the next state so they change cleanly on the clock edge.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 8,
  parameter int RD_TIMEOUT = 64
) (
  input logic               clk,
  input logic               rst,
  bus_master_port_if.master bif
);

  localparam int SH_W  = max_int(ADDR_W, DATA_W);
  localparam int CNT_W = $clog2(SH_W) + 1;
  localparam int TMO_W = $clog2(RD_TIMEOUT) + 1;

  state_t            state_r;
  state_t            state_next_s;
  logic              accept_s;
  logic              err_r;
  logic              err_next_s;
  logic              write_r;
  logic [1:0]        slave_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [TMO_W-1:0]  tmo_r;
  logic              done_next_s;
  logic              drive_next_s;
  logic              on_bus_next_s;

  logic              sh_load_s;
  logic [SH_W-1:0]   sh_load_data_s;
  logic              sh_clear_s;
  logic              sh_shift_s;
  logic [CNT_W-1:0]  sh_len_s;
  logic              sh_ser_next_s;
  logic [DATA_W-1:0] sh_par_next_s;
  logic              sh_at_last_s;

  logic              cmd_ready_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;
  logic              request_r;
  logic [1:0]        slave_sel_r;
  logic              trans_done_r;
  logic              bus_out_r;
  logic              bus_out_valid_r;
  logic              bus_mode_r;

  bus_shift_unit #(
    .W     (SH_W),
    .PW    (DATA_W),
    .CNT_W (CNT_W)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load_s),
    .load_data (sh_load_data_s),
    .clear     (sh_clear_s),
    .shift_en  (sh_shift_s),
    .ser_in    (bif.bus_in),
    .len       (sh_len_s),
    .ser_next  (sh_ser_next_s),
    .par_next  (sh_par_next_s),
    .at_last   (sh_at_last_s)
  );

  // Bit count expected in the current phase; the first read bit is taken in
  // RWAIT, so RDATA only needs the remaining DATA_W-1 bits.
  always_comb begin
    case (state_r)
      ST_ADDR:  sh_len_s = CNT_W'(ADDR_W);
      ST_WDATA: sh_len_s = CNT_W'(DATA_W);
      ST_RDATA: sh_len_s = CNT_W'(DATA_W - 1);
      default:  sh_len_s = CNT_W'(DATA_W);
    endcase
  end

  // Next-state logic and shifter control; grant loss outranks phase completion.
  always_comb begin
    state_next_s   = state_r;
    err_next_s     = err_r;
    accept_s       = 1'b0;
    sh_load_s      = 1'b0;
    sh_load_data_s = {SH_W{1'b0}};
    sh_shift_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bif.cmd_valid) begin
          accept_s     = 1'b1;
          err_next_s   = 1'b0;
          state_next_s = ST_REQ;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bif.grant) begin
          sh_load_s      = 1'b1;
          sh_load_data_s = SH_W'(addr_r);
          state_next_s   = ST_ADDR;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_ADDR: begin
        if (!bif.grant) begin
          err_next_s   = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          sh_shift_s = 1'b1;
          if (sh_at_last_s && write_r) begin
            sh_load_s      = 1'b1;
            sh_load_data_s = SH_W'(wdata_r);
            state_next_s   = ST_WDATA;
          end else if (sh_at_last_s) begin
            state_next_s = ST_RWAIT;
          end else begin
            state_next_s = ST_ADDR;
          end
        end
      end
      ST_WDATA: begin
        if (!bif.grant) begin
          err_next_s   = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          sh_shift_s = 1'b1;
          if (sh_at_last_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_WDATA;
          end
        end
      end
      ST_RWAIT: begin
        if (!bif.grant) begin
          err_next_s   = 1'b1;
          state_next_s = ST_DONE;
        end else if (bif.bus_in_valid) begin
          sh_shift_s   = 1'b1;
          state_next_s = (DATA_W == 1) ? ST_DONE : ST_RDATA;
        end else if (tmo_r == TMO_W'(RD_TIMEOUT - 1)) begin
          err_next_s   = 1'b1;
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_RWAIT;
        end
      end
      ST_RDATA: begin
        if (!bif.grant) begin
          err_next_s   = 1'b1;
          state_next_s = ST_DONE;
        end else if (bif.bus_in_valid) begin
          sh_shift_s = 1'b1;
          if (sh_at_last_s) begin
            state_next_s = ST_DONE;
          end else begin
            state_next_s = ST_RDATA;
          end
        end else begin
          state_next_s = ST_RDATA;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    sh_clear_s    = (state_next_s != state_r);
    done_next_s   = (state_next_s == ST_DONE);
    drive_next_s  = (state_next_s == ST_ADDR) || (state_next_s == ST_WDATA);
    on_bus_next_s = (state_next_s != ST_IDLE) && (state_next_s != ST_REQ);
  end

  // State and error flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      err_r   <= err_next_s;
    end
  end

  // Command capture on acceptance; held for the whole transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_r <= 1'b0;
      slave_r <= 2'b00;
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      write_r <= bif.cmd_write;
      slave_r <= bif.cmd_slave;
      addr_r  <= bif.cmd_addr;
      wdata_r <= bif.cmd_wdata;
    end else begin
      write_r <= write_r;
      slave_r <= slave_r;
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
    end
  end

  // Read timeout counter: restarts on every state change, runs only in RWAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_r <= {TMO_W{1'b0}};
    end else if (state_next_s != state_r) begin
      tmo_r <= {TMO_W{1'b0}};
    end else if (state_r == ST_RWAIT) begin
      tmo_r <= tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
    end else begin
      tmo_r <= tmo_r;
    end
  end

  // Registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready_r     <= 1'b1;
      request_r       <= 1'b0;
      slave_sel_r     <= 2'b00;
      trans_done_r    <= 1'b0;
      rsp_valid_r     <= 1'b0;
      rsp_err_r       <= 1'b0;
      rsp_rdata_r     <= {DATA_W{1'b0}};
      bus_out_r       <= 1'b0;
      bus_out_valid_r <= 1'b0;
      bus_mode_r      <= MODE_READ;
    end else begin
      cmd_ready_r     <= (state_next_s == ST_IDLE);
      request_r       <= (state_next_s != ST_IDLE);
      slave_sel_r     <= (state_next_s == ST_IDLE) ? 2'b00 :
                         (accept_s ? bif.cmd_slave : slave_r);
      trans_done_r    <= done_next_s;
      rsp_valid_r     <= done_next_s;
      rsp_err_r       <= done_next_s && err_next_s;
      bus_out_valid_r <= drive_next_s;
      bus_out_r       <= drive_next_s && sh_ser_next_s;
      bus_mode_r      <= (on_bus_next_s && write_r) ? MODE_WRITE : MODE_READ;
      if (done_next_s && !write_r) begin
        rsp_rdata_r <= sh_par_next_s;
      end else begin
        rsp_rdata_r <= rsp_rdata_r;
      end
    end
  end

  assign bif.cmd_ready     = cmd_ready_r;
  assign bif.request       = request_r;
  assign bif.slave_sel     = slave_sel_r;
  assign bif.trans_done    = trans_done_r;
  assign bif.rsp_valid     = rsp_valid_r;
  assign bif.rsp_err       = rsp_err_r;
  assign bif.rsp_rdata     = rsp_rdata_r;
  assign bif.bus_out       = bus_out_r;
  assign bif.bus_out_valid = bus_out_valid_r;
  assign bif.bus_mode      = bus_mode_r;

endmodule

// File: tb/tb_bus_master_port.sv
// Directed bench for bus_master_port: expected serial bits and responses are
// queued as stimulus is issued; a monitor pops and compares them whenever the
// DUT drives bus_out_valid or rsp_valid.
module tb_bus_master_port;
  import bus_pkg::*;

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       chk_data;
  } rsp_t;

  logic clk;
  logic rst;
  logic cur_mode;
  int   checks;
  int   errors;
  int   lat;
  logic bit_q[$];
  rsp_t rsp_q[$];
  logic mon_b;
  rsp_t mon_r;

  bus_master_port_if #(.ADDR_W(12), .DATA_W(8)) bif();

  bus_master_port #(.ADDR_W(12), .DATA_W(8), .RD_TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) bit_q.push_back(v[i]);
  endtask

  task automatic push_rsp(input logic [7:0] d, input logic e, input logic c);
    rsp_t r;
    r.data = d;
    r.err = e;
    r.chk_data = c;
    rsp_q.push_back(r);
  endtask

  task automatic issue(input logic w, input logic [1:0] s, input logic [11:0] a, input logic [7:0] d);
    bif.cmd_write = w;
    bif.cmd_slave = s;
    bif.cmd_addr  = a;
    bif.cmd_wdata = d;
    bif.cmd_valid = 1'b1;
    step();
    bif.cmd_valid = 1'b0;
  endtask

  // Counts edges until trans_done is seen; returns at the DONE negedge.
  task automatic wait_done(input string nm, output int n);
    logic found;
    found = 1'b0;
    n = 0;
    while (!found && n < 200) begin
      @(negedge clk);
      if (bif.trans_done === 1'b1) found = 1'b1;
      else begin
        step();
        n++;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL %s: trans_done never seen after %0d cycles", nm, n);
    end
  endtask

  // Scoreboard monitor: serial bits and responses against the queues.
  always @(negedge clk) begin
    if (bif.bus_out_valid === 1'b1) begin
      if (bit_q.size() == 0) begin
        check("bus_out_extra", 32'd1, 32'd0);
      end else begin
        mon_b = bit_q.pop_front();
        check("bus_out", {31'd0, bif.bus_out}, {31'd0, mon_b});
        check("bus_mode", {31'd0, bif.bus_mode}, {31'd0, cur_mode});
      end
    end
    if (bif.rsp_valid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        check("rsp_extra", 32'd1, 32'd0);
      end else begin
        mon_r = rsp_q.pop_front();
        check("rsp_err", {31'd0, bif.rsp_err}, {31'd0, mon_r.err});
        check("rsp_done_pair", {31'd0, bif.trans_done}, 32'd1);
        if (mon_r.chk_data) check("rsp_rdata", {24'd0, bif.rsp_rdata}, {24'd0, mon_r.data});
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    logic [7:0] rd;
    checks = 0;
    errors = 0;
    cur_mode = MODE_WRITE;
    rst = 1'b1;
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_slave = 2'b00;
    bif.cmd_addr = 12'h000;
    bif.cmd_wdata = 8'h00;
    bif.grant = 1'b0;
    bif.bus_in = 1'b0;
    bif.bus_in_valid = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_cmd_ready", {31'd0, bif.cmd_ready}, 32'd1);
    check("rst_outs", {24'd0, bif.request, bif.trans_done, bif.rsp_valid, bif.rsp_err,
                       bif.bus_out, bif.bus_out_valid, bif.bus_mode, 1'b0}, 32'd0);
    check("rst_sel_rdata", {22'd0, bif.slave_sel, bif.rsp_rdata}, 32'd0);
    rst = 1'b0;
    step();

    // Write, grant after 3 cycles.
    cur_mode = MODE_WRITE;
    push_bits(32'h0A5, 12);
    push_bits(32'h3C, 8);
    push_rsp(8'h00, 1'b0, 1'b0);
    issue(1'b1, SLAVE2, 12'h0A5, 8'h3C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("wr_req_wait", {29'd0, bif.request, bif.cmd_ready, bif.trans_done}, 32'b100);
      check("wr_slave_sel", {30'd0, bif.slave_sel}, 32'd2);
      step();
    end
    bif.grant = 1'b1;
    wait_done("wr_done", lat);
    check("wr_latency", lat, 32'd21);
    bif.grant = 1'b0;
    step();
    @(negedge clk);
    check("wr_idle_after", {30'd0, bif.request, bif.cmd_ready}, 32'b01);
    check("wr_done_pulse", {31'd0, bif.trans_done}, 32'd0);

    // Read with 2-cycle gaps between bits.
    cur_mode = MODE_READ;
    push_bits(32'h3F0, 12);
    push_rsp(8'hC3, 1'b0, 1'b1);
    bif.grant = 1'b1;
    issue(1'b0, SLAVE1, 12'h3F0, 8'h00);
    repeat (13) step();
    rd = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      bif.bus_in_valid = 1'b0;
      step();
      step();
      bif.bus_in = rd[i];
      bif.bus_in_valid = 1'b1;
      step();
    end
    bif.bus_in_valid = 1'b0;
    @(negedge clk);
    check("rd_trans_done", {31'd0, bif.trans_done}, 32'd1);
    step();
    @(negedge clk);
    check("rd_done_once", {30'd0, bif.trans_done, bif.request}, 32'd0);
    bif.grant = 1'b0;
    step();

    // Read timeout: no valid bit ever arrives.
    push_bits(32'h800, 12);
    push_rsp(8'h00, 1'b1, 1'b0);
    bif.grant = 1'b1;
    issue(1'b0, SLAVE3, 12'h800, 8'h00);
    repeat (13) step();
    wait_done("tmo_done", lat);
    check("tmo_latency", lat, 32'd64);
    bif.grant = 1'b0;
    step();

    // Grant dropped during WDATA bit 4.
    cur_mode = MODE_WRITE;
    push_bits(32'h5A1, 12);
    push_bits(32'hA5, 5);
    push_rsp(8'h00, 1'b1, 1'b0);
    bif.grant = 1'b1;
    issue(1'b1, SLAVE3, 12'h5A1, 8'hA5);
    repeat (17) step();
    bif.grant = 1'b0;
    @(negedge clk);
    check("gl_last_bit_valid", {31'd0, bif.bus_out_valid}, 32'd1);
    step();
    @(negedge clk);
    check("gl_done", {30'd0, bif.trans_done, bif.bus_out_valid}, 32'b10);
    step();
    @(negedge clk);
    check("gl_after", {30'd0, bif.bus_out_valid, bif.request}, 32'd0);
    step();

    // Reset asserted during ADDR, then a fresh command.
    push_bits(32'h123, 3);
    bif.grant = 1'b1;
    issue(1'b1, SLAVE0, 12'h123, 8'h77);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bif.grant = 1'b0;
    @(negedge clk);
    check("mid_rst_outs", {26'd0, bif.cmd_ready, bif.request, bif.bus_out_valid,
                           bif.trans_done, bif.rsp_valid, bif.bus_mode}, 32'b100000);
    check("mid_rst_sel_rdata", {22'd0, bif.slave_sel, bif.rsp_rdata}, 32'd0);
    step();
    push_bits(32'hABC, 12);
    push_bits(32'h5E, 8);
    push_rsp(8'h00, 1'b0, 1'b0);
    bif.grant = 1'b1;
    issue(1'b1, SLAVE1, 12'hABC, 8'h5E);
    wait_done("post_rst_done", lat);
    check("post_rst_latency", lat, 32'd21);
    step();

    // Back-to-back commands with cmd_valid held high.
    push_bits(32'h00F, 12);
    push_bits(32'hF0, 8);
    push_bits(32'hFFE, 12);
    push_bits(32'h01, 8);
    push_rsp(8'h00, 1'b0, 1'b0);
    push_rsp(8'h00, 1'b0, 1'b0);
    issue(1'b1, SLAVE2, 12'h00F, 8'hF0);
    bif.cmd_valid = 1'b1;
    bif.cmd_addr = 12'hFFE;
    bif.cmd_wdata = 8'h01;
    wait_done("b2b_first", lat);
    check("b2b_first_latency", lat, 32'd21);
    step();
    @(negedge clk);
    check("b2b_gap", {30'd0, bif.request, bif.cmd_ready}, 32'b01);
    step();
    bif.cmd_valid = 1'b0;
    wait_done("b2b_second", lat);
    check("b2b_second_latency", lat, 32'd21);
    bif.grant = 1'b0;
    step();
    step();

    check("bits_left", bit_q.size(), 32'd0);
    check("rsp_left", rsp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
